// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//
// Controls start, stop and clear for a chain of cascaded decade (0-9)
// counters that together form a BCD stopwatch or event timer. A prescaler
// running on clk produces a count tick, but only while the FSM is in RUN.
// Digit 0 advances on every tick. Each higher digit advances when every
// digit below it wraps from 9 to 0. A sticky flag records a full-scale wrap.
//
// Optional feature: define STOPWATCH_LAP_EN to add the lap/freeze display
// register and the lap input port. Without it, disp is wired to bcd.
//
// Parameters
//   DIGITS    number of cascaded decade stages (>=1)
//   PRESCALE  clk cycles per count tick (>=1)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     run request (IDLE/PAUSED -> RUN)
//   stop      pause request (RUN -> PAUSED)
//   clear     return to IDLE with everything zeroed (highest priority)
//   lap       freeze/release display (STOPWATCH_LAP_EN only)
//   bcd       live count, digit 0 in [3:0]
//   disp      display value
//   running   high while the FSM is in RUN
//   overflow  sticky: the count wrapped from all-9s to all-0s
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | count at zero, prescaler held, waiting for start
// RUN     | prescaler counting, digits advance on each tick
// PAUSED  | count and partial prescaler period held, waiting for start
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
`ifdef STOPWATCH_LAP_EN
  input  logic                  lap,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   disp,
  output logic                  running,
  output logic                  overflow
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       presc, presc_nxt;
  logic [4*DIGITS-1:0] bcd_nxt;
  logic [4*DIGITS-1:0] bcd_inc;
  logic                all_nines;
  logic                tick;
  logic                overflow_nxt;

  // ---------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------
  assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

  // ---------------------------------------------------------------------
  // Ripple-carry decade increment. The running carry is a local variable,
  // which keeps the whole chain inside one combinational process.
  // all_nines is the carry out of the top digit.
  // ---------------------------------------------------------------------
  always_comb begin
    logic c;
    bcd_inc = bcd;
    c       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
        end
      end
      c = c & (bcd[4*i +: 4] == 4'd9);
    end
    all_nines = c;
  end

  // ---------------------------------------------------------------------
  // Next-state / next-value logic.
  // Priority is clear > stop > start. Clear also suppresses a tick that
  // would otherwise land on the same edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    presc_nxt    = presc;
    bcd_nxt      = bcd;
    overflow_nxt = overflow;

    if (clear) begin
      state_nxt    = ST_IDLE;
      presc_nxt    = '0;
      bcd_nxt      = '0;
      overflow_nxt = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (stop) state_nxt = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase

      // The prescaler holds outside RUN, so a resume continues the
      // partial period that was interrupted.
      if (state == ST_RUN) begin
        presc_nxt = tick ? '0 : presc + PW'(1);
      end

      // A stop that arrives with a tick still applies the increment.
      if (tick) begin
        bcd_nxt = bcd_inc;
        if (all_nines) overflow_nxt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      bcd      <= bcd_nxt;
      overflow <= overflow_nxt;
      running  <= (state_nxt == ST_RUN);
    end
  end

`ifdef STOPWATCH_LAP_EN
  // ---------------------------------------------------------------------
  // Lap freeze. The lap register captures the count as it stood before the
  // edge (pre-increment). disp is registered from the next-state values so
  // that it stays cycle-aligned with bcd.
  // ---------------------------------------------------------------------
  logic                freeze, freeze_nxt;
  logic [4*DIGITS-1:0] lap_q, lap_nxt;

  always_comb begin
    freeze_nxt = freeze;
    lap_nxt    = lap_q;
    if (clear) begin
      freeze_nxt = 1'b0;
      lap_nxt    = '0;
    end else if (lap) begin
      if (freeze) begin
        freeze_nxt = 1'b0;
      end else if (state == ST_RUN) begin
        lap_nxt    = bcd;
        freeze_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze <= 1'b0;
      lap_q  <= '0;
      disp   <= '0;
    end else begin
      freeze <= freeze_nxt;
      lap_q  <= lap_nxt;
      disp   <= freeze_nxt ? lap_nxt : bcd_nxt;
    end
  end
`else
  assign disp = bcd;
`endif

endmodule
